// File: rtl/emu_time_pkg.sv
// Shared types for the emulation-time manager: state encoding and time/timestep widths.
// Purely declarative; no logic lives here.
package emu_time_pkg;

  localparam int TIME_W_DEF = 40;
  localparam int DT_W_DEF   = 27;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } emu_state_t;

  typedef logic [TIME_W_DEF-1:0] emu_time_t;
  typedef logic [DT_W_DEF-1:0]   emu_dt_t;

endpackage

// File: rtl/emu_dt_min.sv
// Unsigned minimum over N_REQ packed timestep lanes, balanced reduction tree.
// Latency: combinational, log2(N_REQ) comparator levels.
// Backpressure: none.
module emu_dt_min #(
  parameter int N_REQ = 2,
  parameter int DT_W  = 27
) (
  input  logic [N_REQ*DT_W-1:0] dt_req,
  output logic [DT_W-1:0]       dt_min
);

  localparam int LVLS = (N_REQ > 1) ? $clog2(N_REQ) : 0;
  localparam int NP   = 1 << LVLS;

  for (genvar l = 0; l <= LVLS; l++) begin : g_lvl
    logic [DT_W-1:0] v [NP >> l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < NP; i++) begin : g_in
        // Pad lanes beyond N_REQ with all-ones so they never win.
        if (i < N_REQ) begin : g_real
          assign v[i] = dt_req[i*DT_W +: DT_W];
        end else begin : g_pad
          assign v[i] = '1;
        end
      end
    end else begin : g_node
      for (genvar i = 0; i < (NP >> l); i++) begin : g_cmp
        assign v[i] = (g_lvl[l-1].v[2*i] <= g_lvl[l-1].v[2*i+1]) ?
                      g_lvl[l-1].v[2*i] : g_lvl[l-1].v[2*i+1];
      end
    end
  end

  assign dt_min = g_lvl[LVLS].v[0];

endmodule

// File: rtl/emu_time_mgr.sv
// Emulation-time manager: grants the smallest timestep request, accumulates time, clamps onto tstop.
// Latency: emu_dt combinational from dt_req; emu_time, running, done, dump_en one clock later.
// Backpressure: none; a zero-valued request stalls time for that cycle.
module emu_time_mgr
  import emu_time_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int TIME_W = TIME_W_DEF,
  parameter int DT_W   = DT_W_DEF,
  parameter int DEC_W  = 16
) (
  input  logic                    emu_clk,
  input  logic                    emu_rst,
  input  logic                    start,
  input  logic [TIME_W-1:0]       tstop,
  input  logic [N_REQ*DT_W-1:0]   dt_req,
  input  logic [DEC_W-1:0]        dec_thr,
  output logic [DT_W-1:0]         emu_dt,
  output logic [TIME_W-1:0]       emu_time,
  output logic                    running,
  output logic                    done,
  output logic                    dump_en
);

  emu_state_t        state_q;
  emu_state_t        state_d;
  logic [TIME_W-1:0] tstop_q;
  logic [TIME_W-1:0] rem;
  logic [DT_W-1:0]   dt_min;
  logic [DEC_W-1:0]  dec_cnt;
  logic              accept;
  logic              advance;

  emu_dt_min #(
    .N_REQ (N_REQ),
    .DT_W  (DT_W)
  ) u_dt_min (
    .dt_req (dt_req),
    .dt_min (dt_min)
  );

  assign rem = tstop_q - emu_time;

  always_comb begin
    state_d = state_q;
    emu_dt  = '0;
    accept  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          accept  = 1'b1;
        end
      end
      RUN: begin
        // Clamp the last step so emu_time lands exactly on tstop_q.
        if (rem < TIME_W'(dt_min)) emu_dt = rem[DT_W-1:0];
        else                       emu_dt = dt_min;
        if (rem == '0) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign advance = (state_q == RUN) && (emu_dt != '0);

  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      state_q  <= IDLE;
      tstop_q  <= '0;
      emu_time <= '0;
      dec_cnt  <= '0;
      dump_en  <= 1'b0;
    end else begin
      state_q <= state_d;
      dump_en <= 1'b0;
      if (accept) begin
        tstop_q  <= tstop;
        emu_time <= '0;
        dec_cnt  <= '0;
      end else if (advance) begin
        emu_time <= emu_time + TIME_W'(emu_dt);
        // Stalled cycles never reach here, so they neither count nor strobe.
        if (dec_cnt == dec_thr) begin
          dec_cnt <= '0;
          dump_en <= 1'b1;
        end else begin
          dec_cnt <= dec_cnt + 1'b1;
        end
      end
    end
  end

  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);

endmodule
